// File: rtl/mask_gen_if.sv
// Row stream from the mask generator to the display-masking pipeline:
// one full-width mask row per valid/ready transfer, with row index and frame-end pulse.
interface mask_gen_if #(
  parameter int ROW_W = 640,
  parameter int ROWS  = 480
);
  localparam int IDX_W = $clog2(ROWS);

  logic [ROW_W-1:0] mask_row;
  logic             row_valid;
  logic             row_ready;
  logic [IDX_W-1:0] row_idx;
  logic             frame_done;

  modport master (
    output mask_row,
    output row_valid,
    output row_idx,
    output frame_done,
    input  row_ready
  );

  modport slave (
    input  mask_row,
    input  row_valid,
    input  row_idx,
    input  frame_done,
    output row_ready
  );
endinterface

// File: rtl/mask_gen_param.sv
// Parametrised row-mask generator: slide right/left, Galois-LFSR random, repeated
// pattern and checkerboard rows, streamed downstream one row per handshake.
module mask_gen_param #(
  parameter int               ROW_W     = 640,
  parameter int               ROWS      = 480,
  parameter int               PAT_MAX   = 32,
  parameter int               RPT_W     = 8,
  parameter logic [PAT_MAX-1:0] LFSR_TAPS = 32'h80200003,
  parameter int               STEP_W    = $clog2(ROW_W)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clk_en,
  input  logic                       load_pattern,
  input  logic                       pattern,
  input  logic [$clog2(PAT_MAX)-1:0] pattern_w,
  input  logic [RPT_W-1:0]           repeated_pattern,
  input  logic [2:0]                 mask_type,
  input  logic [STEP_W-1:0]          step,
  input  logic                       continuous,
  input  logic                       start,
  mask_gen_if.master                 row_if,
  output logic                       busy
);

  localparam int IDX_W = $clog2(ROWS);
  localparam int PW_W  = $clog2(PAT_MAX);

  localparam logic [2:0] MODE_SLIDE_R = 3'b000;
  localparam logic [2:0] MODE_SLIDE_L = 3'b001;
  localparam logic [2:0] MODE_RANDOM  = 3'b010;
  localparam logic [2:0] MODE_REPEAT  = 3'b011;
  localparam logic [2:0] MODE_CHECKER = 3'b100;

  typedef enum logic {S_IDLE, S_ROW} state_e;

  state_e             state_q, state_d;
  logic [PAT_MAX-1:0] pat_q, pat_d;
  logic [PAT_MAX-1:0] lfsr_q, lfsr_d;
  logic [2:0]         mode_q, mode_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [RPT_W-1:0]   rpt_q, rpt_d;
  logic               cont_q, cont_d;
  logic [ROW_W-1:0]   mask_q, mask_d;
  logic               valid_q, valid_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               done_q, done_d;

  logic [PAT_MAX-1:0] lfsr_next;
  logic               last_row;
  int unsigned        shamt;

  // Row 0 of the slide modes: the low W pattern bits, left-aligned at pixel 0.
  function automatic logic [ROW_W-1:0] slide_row0(input logic [PAT_MAX-1:0] p,
                                                  input logic [PW_W-1:0]    pw);
    int unsigned        w;
    logic [PAT_MAX-1:0] keep;
    logic [ROW_W-1:0]   r;
    w    = 32'(pw) + 32'd1;
    keep = ~({PAT_MAX{1'b1}} << w);
    r    = ROW_W'(p & keep);
    return r << (unsigned'(ROW_W) - w);
  endfunction

  function automatic logic [ROW_W-1:0] rot_r(input logic [ROW_W-1:0] x, input int unsigned s);
    logic [2*ROW_W-1:0] d;
    d = {x, x} >> s;
    return d[ROW_W-1:0];
  endfunction

  function automatic logic [ROW_W-1:0] rot_l(input logic [ROW_W-1:0] x, input int unsigned s);
    logic [2*ROW_W-1:0] d;
    d = {x, x} << s;
    return d[2*ROW_W-1:ROW_W];
  endfunction

  function automatic logic [ROW_W-1:0] rep_lfsr(input logic [PAT_MAX-1:0] v);
    return {(ROW_W/PAT_MAX){v}};
  endfunction

  function automatic logic [ROW_W-1:0] rep_rpt(input logic [RPT_W-1:0] v);
    return {(ROW_W/RPT_W){v}};
  endfunction

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    state_d   = state_q;
    pat_d     = pat_q;
    lfsr_d    = lfsr_q;
    mode_d    = mode_q;
    step_d    = step_q;
    rpt_d     = rpt_q;
    cont_d    = cont_q;
    mask_d    = mask_q;
    valid_d   = valid_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    lfsr_next = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
    last_row  = (idx_q == IDX_W'(ROWS - 1));
    shamt     = 32'(step_q) % unsigned'(ROW_W);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          // pattern_w only shapes row 0, so it is consumed here rather than kept.
          mode_d  = mask_type;
          step_d  = step;
          rpt_d   = repeated_pattern;
          cont_d  = continuous;
          lfsr_d  = (pat_q == '0) ? PAT_MAX'(1) : pat_q;
          idx_d   = '0;
          valid_d = 1'b1;
          state_d = S_ROW;
          case (mask_type)
            MODE_SLIDE_R, MODE_SLIDE_L: mask_d = slide_row0(pat_q, pattern_w);
            MODE_RANDOM:                mask_d = rep_lfsr(lfsr_d);
            MODE_REPEAT, MODE_CHECKER:  mask_d = rep_rpt(repeated_pattern);
            default:                    mask_d = '0;
          endcase
        end else if (load_pattern) begin
          pat_d = {pat_q[PAT_MAX-2:0], pattern};
        end
      end

      S_ROW: begin
        if (valid_q && row_if.row_ready) begin
          idx_d  = last_row ? '0 : idx_q + IDX_W'(1);
          done_d = last_row;
          if (last_row && !cont_q) begin
            // Single-frame run ends: the last row stays visible on mask_row.
            state_d = S_IDLE;
            valid_d = 1'b0;
          end else begin
            case (mode_q)
              MODE_SLIDE_R: mask_d = rot_r(mask_q, shamt);
              MODE_SLIDE_L: mask_d = rot_l(mask_q, shamt);
              MODE_RANDOM: begin
                lfsr_d = lfsr_next;
                mask_d = rep_lfsr(lfsr_next);
              end
              MODE_REPEAT:  mask_d = mask_q;
              MODE_CHECKER: mask_d = idx_d[0] ? ~rep_rpt(rpt_q) : rep_rpt(rpt_q);
              default:      mask_d = '0;
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      lfsr_q  <= '0;
      mode_q  <= '0;
      step_q  <= '0;
      rpt_q   <= '0;
      cont_q  <= 1'b0;
      mask_q  <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else if (clk_en) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      pat_q   <= pat_d;
      lfsr_q  <= lfsr_d;
      mode_q  <= mode_d;
      step_q  <= step_d;
      rpt_q   <= rpt_d;
      cont_q  <= cont_d;
      mask_q  <= mask_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  assign row_if.mask_row   = mask_q;
  assign row_if.row_valid  = valid_q;
  assign row_if.row_idx    = idx_q;
  assign row_if.frame_done = done_q;
  assign busy              = (state_q == S_ROW);

endmodule
